// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the command sequencer: opcodes, FSM state encoding
// and command-word field positions.
package cmd_sequencer_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_EXEC   = 8'h03;
  localparam logic [7:0] OP_CLRERR = 8'h04;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;
  localparam logic [2:0] ST_EXEC    = 3'd6;

  localparam int OPC_MSB   = 63;
  localparam int OPC_LSB   = 56;
  localparam int ADDR_MSB  = 55;
  localparam int PAY_MSB   = 47;
  localparam int WDATA_MSB = 31;

endpackage

// File: rtl/cmd_sequencer_edge_detect.sv
// Registered rising-edge detector; the pulse appears the cycle after the
// input is first sampled high, and reset clears the history.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Captures 64-bit commands from the parallel receiver, decodes them and drives
// register writes, read responses and guarded execute handshakes.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int REG_AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       cmd_in,
  input  logic              cmd_ready,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  input  logic              resp_ack,
  output logic              exec_valid,
  output logic [47:0]       exec_arg,
  input  logic              exec_done,
  output logic              busy,
  output logic              err_opcode,
  output logic              err_timeout,
  output logic [7:0]        drop_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             cap;
  logic [2:0]       state_q, state_d;
  logic [63:0]      cmd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      resp_data_q;
  logic [47:0]      exec_arg_q;
  logic             busy_q;
  logic             err_op_q, err_op_d;
  logic             err_to_q, err_to_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       opcode;

  edge_detect u_ready_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (cmd_ready),
    .rise_o (cap)
  );

  assign opcode = cmd_q[OPC_MSB:OPC_LSB];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_op_d = err_op_q;
    err_to_d = err_to_q;
    drop_d   = drop_q;
    if (cap && state_q != ST_IDLE) drop_d = sat_inc8(drop_q);
    case (state_q)
      ST_IDLE:    if (cap) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOP:   state_d = ST_IDLE;
          OP_WRITE: state_d = ST_WRITE;
          OP_READ:  state_d = ST_RD_ADDR;
          OP_EXEC: begin
            state_d = ST_EXEC;
            cnt_d   = '0;
          end
          OP_CLRERR: begin
            // Clear wins over a drop landing in the same cycle.
            state_d  = ST_IDLE;
            err_op_d = 1'b0;
            err_to_d = 1'b0;
            drop_d   = 8'd0;
          end
          default: begin
            state_d  = ST_IDLE;
            err_op_d = 1'b1;
          end
        endcase
      end
      ST_WRITE:   state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_RESP;
      ST_RESP:    if (resp_ack) state_d = ST_IDLE;
      ST_EXEC: begin
        // A done arriving on the final count still completes cleanly.
        if (exec_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      exec_arg_q  <= '0;
      busy_q      <= 1'b0;
      err_op_q    <= 1'b0;
      err_to_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != ST_IDLE);
      err_op_q <= err_op_d;
      err_to_q <= err_to_d;
      drop_q   <= drop_d;
      if (state_q == ST_IDLE && cap) cmd_q <= cmd_in;
      if (state_q == ST_RD_DATA) resp_data_q <= reg_rdata;
      if (state_q == ST_DECODE && state_d == ST_EXEC) exec_arg_q <= cmd_q[PAY_MSB:0];
    end
  end

  assign reg_we      = (state_q == ST_WRITE);
  assign resp_valid  = (state_q == ST_RESP);
  assign exec_valid  = (state_q == ST_EXEC);
  assign reg_addr    = cmd_q[ADDR_MSB -: REG_AW];
  assign reg_wdata   = cmd_q[WDATA_MSB:0];
  assign resp_data   = resp_data_q;
  assign exec_arg    = exec_arg_q;
  assign busy        = busy_q;
  assign err_opcode  = err_op_q;
  assign err_timeout = err_to_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: stimulus pushes expected writes, read
// responses and execute arguments; a negedge monitor pops and compares them.
module tb_cmd_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cmd_in;
  logic        cmd_ready;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ack;
  logic        exec_valid;
  logic [47:0] exec_arg;
  logic        exec_done;
  logic        busy;
  logic        err_opcode;
  logic        err_timeout;
  logic [7:0]  drop_count;

  cmd_sequencer #(.TIMEOUT(TO), .REG_AW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_in      (cmd_in),
    .cmd_ready   (cmd_ready),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_ack    (resp_ack),
    .exec_valid  (exec_valid),
    .exec_arg    (exec_arg),
    .exec_done   (exec_done),
    .busy        (busy),
    .err_opcode  (err_opcode),
    .err_timeout (err_timeout),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          wr_seen = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [47:0] exp_ex[$];
  logic [31:0] mregs[256];
  logic [31:0] mem[256];
  bit          m_eop, m_eto;
  int          m_drops;
  logic        ex_prev = 1'b0;
  wr_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register file seen by the DUT: one-cycle read latency, write on strobe.
  always @(negedge clk) begin
    reg_rdata = mem[reg_addr];
    if (reg_we) mem[reg_addr] = reg_wdata;
  end

  always @(negedge clk) begin
    if (reg_we) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h expected none", reg_addr, reg_wdata);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", reg_addr, mon_e.addr);
        check("wr_data", reg_wdata, mon_e.data);
      end
    end
    if (resp_valid && resp_ack) begin
      if (exp_rd.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got response 0x%0h expected none", resp_data);
      end else check("rd_data", resp_data, exp_rd.pop_front());
    end
    if (exec_valid && !ex_prev) begin
      if (exp_ex.size() == 0) begin
        checks++; failures++;
        $display("FAIL ex_unexpected: got exec arg 0x%0h expected none", exec_arg);
      end else check("ex_arg", exec_arg, exp_ex.pop_front());
    end
    ex_prev = exec_valid;
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Behavioural model: what each command must produce, decided at issue time.
  task automatic model_issue(input logic [63:0] c, input int d);
    logic [7:0] op, a;
    op = c[63:56];
    a  = c[55:48];
    case (op)
      8'h00: ;
      8'h01: begin
        exp_wr.push_back('{addr: a, data: c[31:0]});
        mregs[a] = c[31:0];
      end
      8'h02: exp_rd.push_back(mregs[a]);
      8'h03: begin
        exp_ex.push_back(c[47:0]);
        if (!(d >= 1 && d <= TO)) m_eto = 1'b1;
      end
      8'h04: begin
        m_eop = 1'b0; m_eto = 1'b0; m_drops = 0;
      end
      default: m_eop = 1'b1;
    endcase
  endtask

  task automatic model_drop();
    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err_opcode"}, err_opcode, m_eop);
    check({tag, "_err_timeout"}, err_timeout, m_eto);
    check({tag, "_drop_count"}, drop_count, m_drops);
  endtask

  task automatic send(input logic [63:0] c, input int hold);
    @(posedge clk); #1;
    cmd_in = c;
    cmd_ready = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (busy && n < 300) begin @(posedge clk); #1; n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic rd_wait();
    int n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("rd_present", resp_valid, 1);
  endtask

  task automatic rd_respond(input int d, output int hi);
    rd_wait();
    hi = 0;
    while (resp_valid && hi < 2000) begin
      hi++;
      resp_ack = (hi == d);
      @(posedge clk); #1;
    end
    resp_ack = 1'b0;
  endtask

  task automatic ex_respond(input int d, output int hi);
    int n = 0;
    while (!exec_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("ex_present", exec_valid, 1);
    hi = 0;
    while (exec_valid && hi < 2000) begin
      hi++;
      exec_done = (hi == d);
      @(posedge clk); #1;
    end
    exec_done = 1'b0;
  endtask

  task automatic run_cmd(input logic [63:0] c, input int hold, input int d);
    int hi;
    model_issue(c, d);
    fork
      send(c, hold);
      begin
        if (c[63:56] == 8'h02) begin
          rd_respond(d, hi);
          check("rd_len", hi, d);
        end else if (c[63:56] == 8'h03) begin
          ex_respond(d, hi);
          check("ex_len", hi, (d >= 1 && d <= TO) ? d : TO);
        end
      end
    join
    wait_idle("cmd");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c;
    logic [7:0]  op;
    int          d, hi;

    for (int i = 0; i < 256; i++) begin
      mregs[i] = init_val(i);
      mem[i]   = init_val(i);
    end
    m_eop = 1'b0; m_eto = 1'b0; m_drops = 0;
    rst = 1'b1; cmd_in = '0; cmd_ready = 1'b0; resp_ack = 1'b0; exec_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {reg_we, resp_valid, exec_valid}, 0);
    check("rst_status", {err_opcode, err_timeout, drop_count}, 0);
    check("rst_data", {reg_addr, reg_wdata, resp_data, exec_arg}, 0);
    rst = 1'b0;

    // WRITE with latency: strobe exactly in the third cycle after ready rises.
    c = 64'h01_05_0000_DEADBEEF;
    model_issue(c, 0);
    @(posedge clk); #1;
    cmd_in = c; cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("wr_latency", reg_we, (k == 3));
    end
    cmd_ready = 1'b0;
    wait_idle("write");
    check("wr_count", wr_seen, 1);
    check_status("write");

    // READ with latency 5 and ack held off 10 cycles.
    run_cmd(64'h01_0A_0000_12345678, 4, 0);
    c = 64'h02_0A_0000_0000_0000;
    model_issue(c, 10);
    @(posedge clk); #1;
    cmd_in = c; cmd_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) cmd_ready = 1'b0;
      check("rd_latency", resp_valid, (k == 5));
    end
    rd_respond(10, hi);
    check("rd_hold", hi, 10);
    wait_idle("read");
    check_status("read");

    // EXEC: success, timeout, CLRERR, done on the final timeout cycle.
    run_cmd(64'h03_00_0000_0000_CAFE, 4, 10);
    check_status("ex_ok");
    run_cmd(64'h03_00_0000_0000_CAFE, 4, 0);
    check_status("ex_to");
    run_cmd(64'h04_00_0000_0000_0000, 4, 0);
    check_status("clr1");
    run_cmd(64'h03_00_0000_0000_BEEF, 4, TO);
    check_status("ex_coll");

    // Drops during a stalled READ, then saturation, then CLRERR.
    c = 64'h02_0A_0000_0000_0000;
    model_issue(c, 1);
    fork
      send(c, 2);
      rd_wait();
    join
    cmd_in = 64'h01_77_0000_11111111;
    for (int k = 0; k < 2; k++) begin pulse_ready(); model_drop(); end
    check("drop_two", drop_count, m_drops);
    check("drop_addr_kept", reg_addr, 8'h0A);
    for (int k = 0; k < 300; k++) begin pulse_ready(); model_drop(); end
    check("drop_sat", drop_count, m_drops);
    rd_respond(1, hi);
    wait_idle("drop");
    run_cmd(64'h04_00_0000_0000_0000, 3, 0);
    check_status("clr2");

    // Bad opcode must flag an error and write nothing.
    d = wr_seen;
    run_cmd(64'h7F_05_0000_0BAD0BAD, 4, 0);
    check_status("badop");
    check("badop_no_write", wr_seen, d);

    // Reset while in RESP, with ready already high across reset release.
    c = 64'h02_0A_0000_0000_0000;
    model_issue(c, 0);
    fork
      send(c, 2);
      rd_wait();
    join
    pulse_ready(); model_drop();
    rst = 1'b1;
    cmd_in = 64'h01_33_0000_00C0FFEE;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_status", {err_opcode, err_timeout, drop_count}, 0);
    check("rstmid_data", {reg_addr, reg_wdata, resp_data, exec_arg}, 0);
    rst = 1'b0;
    exp_rd.delete();
    m_eop = 1'b0; m_eto = 1'b0; m_drops = 0;
    model_issue(cmd_in, 0);
    wait_idle("rst_edge");
    cmd_ready = 1'b0;
    check_status("rst_edge");

    // Randomised command mix.
    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(0, 5));
      if (op == 8'd5) op = 8'($urandom_range(5, 255));
      c = {op, 5'b0, 3'($urandom_range(0, 7)), 16'($urandom), 32'($urandom)};
      d = (op == 8'h02) ? $urandom_range(1, 5) : (op == 8'h03) ? $urandom_range(0, 20) : 0;
      run_cmd(c, $urandom_range(1, 6), d);
      check_status("rnd");
    end

    check("wr_q_empty", exp_wr.size(), 0);
    check("rd_q_empty", exp_rd.size(), 0);
    check("ex_q_empty", exp_ex.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
